// File: rtl/mix2_ctrl_pkg.sv
// Shared types and widths for the mixer retune controller.
package mix2_ctrl_pkg;

  localparam int PHI_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } tune_state_t;

  typedef enum logic {
    SRC_HOST,
    SRC_SCAN
  } tune_src_t;

endpackage

// File: rtl/mix2_tune_ctrl_slew.sv
// One slew step toward a target phase increment along the shortest path
// around the 2^PHI_W circle. Purely combinational.
module phase_slew_step
  import mix2_ctrl_pkg::*;
(
  input  logic [PHI_W-1:0] cur,
  input  logic [PHI_W-1:0] target,
  input  logic [PHI_W-1:0] max_step,
  output logic [PHI_W-1:0] step_next,
  output logic             reached
);

  logic [PHI_W-1:0] diff;
  logic [PHI_W-1:0] mag;
  logic             neg;

  // Signed modular distance; the most negative distance counts as negative,
  // and its magnitude is still exact as an unsigned value.
  always_comb begin
    diff    = target - cur;
    neg     = diff[PHI_W-1];
    mag     = neg ? (PHI_W'(0) - diff) : diff;
    reached = (mag <= max_step);
    if (reached) begin
      step_next = target;
    end else if (neg) begin
      step_next = cur - max_step;
    end else begin
      step_next = cur + max_step;
    end
  end

endmodule

// File: rtl/mix2_tune_ctrl.sv
// Retune controller for the dual-channel mixer NCO: round-robin arbitration
// between host and band-scan requests, then a jump or a linear slew of the
// selected phase increment, followed by a mute hold while the NCO settles.
module mix2_tune_ctrl
  import mix2_ctrl_pkg::*;
#(
  parameter logic [PHI_W-1:0] MAX_STEP      = 32'h0001_0000,
  parameter int               TICK_DIV      = 16,
  parameter int               SETTLE_CYCLES = 64,
  parameter logic [PHI_W-1:0] PHI0_INIT     = 32'h0000_0000,
  parameter logic [PHI_W-1:0] PHI1_INIT     = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             host_ch,
  input  logic [PHI_W-1:0] host_phi,
  input  logic             host_jump,
  input  logic             scan_valid,
  output logic             scan_ready,
  input  logic             scan_ch,
  input  logic [PHI_W-1:0] scan_phi,
  input  logic             scan_jump,
  output logic [PHI_W-1:0] phi0,
  output logic [PHI_W-1:0] phi1,
  output logic             busy,
  output logic             mute,
  output logic             done,
  output logic             done_src
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);

  tune_state_t      state_reg;
  tune_src_t        src_reg;
  tune_src_t        last_grant_reg;
  tune_src_t        done_src_reg;
  logic             ch_reg;
  logic             jump_reg;
  logic [PHI_W-1:0] target_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [SET_W-1:0] settle_reg;
  logic             busy_reg;
  logic             mute_reg;
  logic             done_reg;

  logic [PHI_W-1:0] phi_bus [2];

  logic             idle;
  logic             accept_host;
  logic             accept_scan;
  logic             step_fire;
  logic             phi_wr;
  logic             enter_settle;
  logic [PHI_W-1:0] cur_phi;
  logic [PHI_W-1:0] slew_next;
  logic [PHI_W-1:0] phi_next;
  logic             slew_reached;

  // Ready only in IDLE; on a tie the source that did not win last time goes.
  assign idle        = (state_reg == IDLE);
  assign host_ready  = idle && (!scan_valid || last_grant_reg == SRC_SCAN);
  assign scan_ready  = idle && (!host_valid || last_grant_reg == SRC_HOST);
  assign accept_host = host_valid && host_ready;
  assign accept_scan = scan_valid && scan_ready;

  assign cur_phi   = phi_bus[ch_reg];
  assign step_fire = (tick_reg == TICK_LAST);

  phase_slew_step u_step (
    .cur      (cur_phi),
    .target   (target_reg),
    .max_step (MAX_STEP),
    .step_next(slew_next),
    .reached  (slew_reached)
  );

  assign phi_wr       = (state_reg == RAMP) && (jump_reg || step_fire);
  assign phi_next     = jump_reg ? target_reg : slew_next;
  assign enter_settle = (state_reg == RAMP) && (jump_reg || (step_fire && slew_reached));

  // One register per channel; only the channel latched at accept is written.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [PHI_W-1:0] phi_reg;

      // Channel phase-increment register.
      always_ff @(posedge clk) begin
        if (rst) begin
          phi_reg <= (gi == 0) ? PHI0_INIT : PHI1_INIT;
        end else if (phi_wr && (ch_reg == 1'(gi))) begin
          phi_reg <= phi_next;
        end
      end

      assign phi_bus[gi] = phi_reg;
    end
  endgenerate

  // Retune sequencer: latch the request, ramp or jump, then hold mute.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      src_reg        <= SRC_HOST;
      last_grant_reg <= SRC_SCAN;
      done_src_reg   <= SRC_HOST;
      ch_reg         <= 1'b0;
      jump_reg       <= 1'b0;
      target_reg     <= '0;
      tick_reg       <= '0;
      settle_reg     <= '0;
      busy_reg       <= 1'b0;
      mute_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept_host || accept_scan) begin
            ch_reg         <= accept_host ? host_ch   : scan_ch;
            target_reg     <= accept_host ? host_phi  : scan_phi;
            jump_reg       <= accept_host ? host_jump : scan_jump;
            src_reg        <= accept_host ? SRC_HOST  : SRC_SCAN;
            last_grant_reg <= accept_host ? SRC_HOST  : SRC_SCAN;
            busy_reg       <= 1'b1;
            mute_reg       <= 1'b1;
            tick_reg       <= '0;
            state_reg      <= RAMP;
          end
        end
        RAMP: begin
          tick_reg <= step_fire ? '0 : tick_reg + TICK_W'(1);
          if (enter_settle) begin
            settle_reg <= SET_LOAD;
            state_reg  <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_reg == '0) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            mute_reg     <= 1'b0;
            done_reg     <= 1'b1;
            done_src_reg <= src_reg;
          end else begin
            settle_reg <= settle_reg - SET_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign phi0     = phi_bus[0];
  assign phi1     = phi_bus[1];
  assign busy     = busy_reg;
  assign mute     = mute_reg;
  assign done     = done_reg;
  assign done_src = done_src_reg;

endmodule
